keccak_src_feeder: RTL and testbench

Transmitter for the Keccak core's source port. It accepts a hash command and an upstream stream of 32-bit message words, frames them as one command header word followed by zero-masked message words, and presents them through a small FIFO on the `src_ready`/`src_read` handshake that the Keccak control logic consumes. It sits between the Dilithium sampling/packing datapath and `keccak_control`, and sends single-segment messages only.

---
 rtl/keccak_src_feeder.sv | 133 +++++++++++++
 tb/tb_keccak_src_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keccak_src_feeder.sv
// ============================================================================
// keccak_src_feeder: frames a hash command header plus zero-masked message
// words into a small FIFO feeding the Keccak core source port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module keccak_src_feeder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] msg_len,
    output logic        busy,
    output logic        done,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] src_data,
    output logic        src_ready,
    input  logic        src_read,
    output logic        final_segment
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    mode_q;
    logic [15:0]   len_q;
    logic [14:0]   words_left;
    logic [14:0]   words_init;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, done_q;
    logic [31:0]   push_data, tail_mask;

    assign words_init = {1'b0, msg_len[15:2]} + {14'd0, |msg_len[1:0]};

    // Bytes at or beyond the message length in the final word are zeroed
    always_comb begin
        tail_mask = 32'hFFFF_FFFF;
        case (len_q[1:0])
            2'd1:    tail_mask = 32'hFF00_0000;
            2'd2:    tail_mask = 32'hFFFF_0000;
            2'd3:    tail_mask = 32'hFFFF_FF00;
            default: tail_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_data = 32'd0;
        in_ready  = 1'b0;
        pop       = src_read && (count != '0);
        case (state)
            IDLE: begin
                if (start) state_nx = HDR;
            end
            HDR: begin
                push      = 1'b1;
                push_data = {mode_q, 14'd0, len_q};
                state_nx  = (words_left != 15'd0) ? DATA : DRAIN;
            end
            DATA: begin
                in_ready  = (count < FULL_CNT) && (words_left != 15'd0);
                push      = in_valid && in_ready;
                push_data = (words_left == 15'd1) ? (in_data & tail_mask) : in_data;
                if (push && words_left == 15'd1) state_nx = DRAIN;
            end
            DRAIN: begin
                if (pop && count == ONE_CNT) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 2'd0;
            len_q      <= 16'd0;
            words_left <= 15'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (state == DRAIN) && pop && (count == ONE_CNT);
            if (state == IDLE && start) begin
                mode_q     <= mode;
                len_q      <= msg_len;
                words_left <= words_init;
            end else if (state == DATA && push) begin
                words_left <= words_left - 15'd1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign src_ready     = (count != '0);
    assign src_data      = src_ready ? mem[rd_ptr] : 32'd0;
    assign done          = done_q;
    assign busy          = (state != IDLE) || done_q;
    assign final_segment = busy;

endmodule

`default_nettype wire

// File: tb/tb_keccak_src_feeder.sv
// Testbench for keccak_src_feeder: table-driven messages, corner sequences and
// randomized messages checked against a frame-level reference model.
`default_nettype none

module tb_keccak_src_feeder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] msg_len;
    logic        busy, done, in_ready, src_ready, final_segment;
    logic [31:0] in_data, src_data;
    logic        in_valid, src_read;

    keccak_src_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .msg_len(msg_len),
        .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .src_data(src_data), .src_ready(src_ready),
        .src_read(src_read), .final_segment(final_segment)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] words [256];
    logic [31:0] got [$];
    int last_cycles;
    int acc_at_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Runs one message from IDLE; the model is the list of framed words and
    // the running count of pushes and pops.
    task automatic run_msg(input logic [1:0] m, input logic [15:0] len,
                           input int vld_pct, input int rd_pct, input int rd_hold,
                           input bit poke);
        logic [31:0] exp_q [$];
        logic [31:0] w;
        int L, n, idx, pushed, popped, cyc, occ;
        bit hdr_cycle, done_next, exp_ir, exp_sr, take, pop;
        L = int'(len);
        n = (L + 3) / 4;
        exp_q = {};
        exp_q.push_back({m, 14'd0, len});
        for (int i = 0; i < n; i++) begin
            w = words[i];
            if (i == n - 1 && (L % 4) != 0) w = w & ~(32'hFFFF_FFFF >> (8 * (L % 4)));
            exp_q.push_back(w);
        end
        got = {};
        acc_at_hold = -1;
        @(negedge clk);
        start = 1'b1; mode = m; msg_len = len; in_valid = 1'b0; src_read = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx = 0; pushed = 0; popped = 0; cyc = 1;
        hdr_cycle = 1'b1; done_next = 1'b0;
        forever begin
            occ    = pushed - popped;
            exp_ir = !hdr_cycle && (idx < n) && (occ < DEPTH);
            exp_sr = (occ > 0);
            chk("busy", {31'd0, busy}, 32'd1);
            chk("final_segment", {31'd0, final_segment}, 32'd1);
            chk("done", {31'd0, done}, {31'd0, done_next});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            chk("src_ready", {31'd0, src_ready}, {31'd0, exp_sr});
            if (exp_sr) chk("src_data", src_data, exp_q[popped]);
            if (done_next) break;
            if (cyc >= 4000) begin
                chk("timeout", 32'd1, 32'd0);
                break;
            end
            if (cyc == rd_hold) acc_at_hold = idx;
            in_valid = ($urandom_range(0, 99) < vld_pct);
            in_data  = (idx < n) ? words[idx] : $urandom;
            src_read = (cyc >= rd_hold) && ($urandom_range(0, 99) < rd_pct);
            start    = poke && ($urandom_range(0, 7) == 0);
            if (start) begin
                mode = 2'($urandom); msg_len = 16'($urandom);
            end
            take = in_valid && exp_ir;
            pop  = src_read && exp_sr;
            if (pop) begin
                got.push_back(src_data);
                popped++;
                if (popped == n + 1) done_next = 1'b1;
            end
            if (take) begin
                idx++; pushed++;
            end
            if (hdr_cycle) begin
                pushed++; hdr_cycle = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        last_cycles = cyc;
        start = 1'b0; in_valid = 1'b0; src_read = 1'b0;
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [15:0] len;
        logic [31:0] w0, w1;
        int          npop;
        logic [31:0] e0, e1, e2;
        int          cycles;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{2'd2, 16'd8, 32'hA1B2C3D4, 32'h11223344, 3, 32'h80000008, 32'hA1B2C3D4, 32'h11223344, 5};
        vecs[1] = '{2'd0, 16'd5, 32'hDEADBEEF, 32'hCAFEF00D, 3, 32'h00000005, 32'hDEADBEEF, 32'hCA000000, 5};
        vecs[2] = '{2'd1, 16'd0, 32'h12345678, 32'h9ABCDEF0, 1, 32'h40000000, 32'h0, 32'h0, 3};
        vecs[3] = '{2'd3, 16'd6, 32'h12345678, 32'h9ABCDEF0, 3, 32'hC0000006, 32'h12345678, 32'h9ABC0000, 5};
        vecs[4] = '{2'd0, 16'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFF00, 5};
        vecs[5] = '{2'd1, 16'd1, 32'hAABBCCDD, 32'h55667788, 2, 32'h40000001, 32'hAA000000, 32'h0, 4};

        rst = 1'b1; start = 1'b0; mode = 2'd0; msg_len = 16'd0;
        in_data = 32'd0; in_valid = 1'b0; src_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_src_ready", {31'd0, src_ready}, 32'd0);
        chk("reset_src_data", src_data, 32'd0);
        rst = 1'b0;

        // Pops while idle and empty must change nothing
        src_read = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_pop_src_ready", {31'd0, src_ready}, 32'd0);
            chk("idle_pop_src_data", src_data, 32'd0);
            chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        end
        src_read = 1'b0;

        for (int v = 0; v < 6; v++) begin
            words[0] = vecs[v].w0;
            words[1] = vecs[v].w1;
            run_msg(vecs[v].m, vecs[v].len, 100, 100, 0, 1'b0);
            chk("vec_npop", got.size(), vecs[v].npop);
            if (got.size() >= 1) chk("vec_pop0", got[0], vecs[v].e0);
            if (vecs[v].npop >= 2 && got.size() >= 2) chk("vec_pop1", got[1], vecs[v].e1);
            if (vecs[v].npop >= 3 && got.size() >= 3) chk("vec_pop2", got[2], vecs[v].e2);
            chk("vec_latency", last_cycles, vecs[v].cycles);
        end

        // Backpressure across pointer wrap: header plus three data words fill the FIFO
        for (int i = 0; i < 10; i++) words[i] = $urandom;
        run_msg(2'd3, 16'd40, 100, 100, 20, 1'b0);
        chk("bp_accepted_at_hold", acc_at_hold, 3);
        chk("bp_npop", got.size(), 11);

        // Full-rate throughput on a longer message
        for (int i = 0; i < 250; i++) words[i] = $urandom;
        run_msg(2'd1, 16'd1000, 100, 100, 0, 1'b0);
        chk("throughput_cycles", last_cycles, 250 + 3);

        // Mid-message start pulses must be ignored
        for (int i = 0; i < 12; i++) words[i] = $urandom;
        run_msg(2'd2, 16'd45, 70, 60, 0, 1'b1);

        // Asynchronous reset with two data words buffered
        @(negedge clk);
        start = 1'b1; mode = 2'd0; msg_len = 16'd40;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 32'h0BADF00D; src_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_src_ready", {31'd0, src_ready}, 32'd1);
        chk("pre_reset_src_data", src_data, 32'h00000028);
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_src_ready", {31'd0, src_ready}, 32'd0);
        chk("rst_src_data", src_data, 32'd0);
        chk("rst_final_segment", {31'd0, final_segment}, 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_msg(2'd2, 16'd10, 100, 100, 0, 1'b0);
        chk("post_reset_npop", got.size(), 4);

        // Randomized messages
        for (int r = 0; r < 25; r++) begin
            logic [15:0] len;
            len = 16'($urandom_range(0, 200));
            for (int i = 0; i < 51; i++) words[i] = $urandom;
            run_msg(2'($urandom), len, int'($urandom_range(30, 100)),
                    int'($urandom_range(20, 100)), 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
